// File: rtl/sap_ctrl_pkg.sv
// Shared types for the SAP-1.5 control sequencer: opcodes, FSM states and the
// control word carrying every bus enable and load strobe.
package sap_ctrl_pkg;

    localparam int unsigned OpcodeWidth = 4;

    typedef enum logic [3:0] {
        OpNop = 4'h0,
        OpLda = 4'h1,
        OpLdb = 4'h2,
        OpAdd = 4'h3,
        OpSub = 4'h4,
        OpSta = 4'h5,
        OpLdi = 4'h6,
        OpJmp = 4'h7,
        OpOut = 4'hE,
        OpHlt = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        StFetchAddr,
        StFetchInstr,
        StDecode,
        StEx1,
        StEx2,
        StEx3,
        StHalt
    } state_t;

    typedef struct packed {
        logic pc_inc;
        logic pc_oe;
        logic pc_load;
        logic mar_load;
        logic ram_oe;
        logic ram_we;
        logic ir_load;
        logic ir_oe;
        logic a_load;
        logic a_oe;
        logic b_load;
        logic alu_oe;
        logic alu_sub;
        logic flags_load;
        logic out_load;
        logic halt;
        logic illegal_op;
        logic instr_done;
    } ctrl_word_t;

    localparam ctrl_word_t CtrlIdle = '0;

    function automatic logic is_defined(opcode_t op);
        return (op <= OpJmp) || (op == OpOut) || (op == OpHlt);
    endfunction

    // Opcodes whose EX1 places the operand address into MAR.
    function automatic logic uses_mem(opcode_t op);
        return (op == OpLda) || (op == OpLdb) || (op == OpAdd) || (op == OpSub) || (op == OpSta);
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational microcode: maps (state, opcode) to the control word and the
// next FSM state.
module control_decode
    import sap_ctrl_pkg::*;
#(
    parameter bit HaltOnIllegal = 1'b0
) (
    input  state_t     state_i,
    input  opcode_t    op_i,
    output state_t     state_next_o,
    output ctrl_word_t ctrl_o
);

    always_comb begin
        state_next_o = StFetchAddr;
        unique case (state_i)
            StFetchAddr:  state_next_o = StFetchInstr;
            StFetchInstr: state_next_o = StDecode;
            StDecode: begin
                if (op_i == OpHlt || (!is_defined(op_i) && HaltOnIllegal)) begin
                    state_next_o = StHalt;
                end else if (is_defined(op_i) && op_i != OpNop) begin
                    state_next_o = StEx1;
                end
            end
            StEx1:   if (uses_mem(op_i)) state_next_o = StEx2;
            StEx2:   if (op_i == OpAdd || op_i == OpSub) state_next_o = StEx3;
            StEx3:   state_next_o = StFetchAddr;
            StHalt:  state_next_o = StHalt;
            default: state_next_o = StFetchAddr;
        endcase
    end

    always_comb begin
        ctrl_o = CtrlIdle;
        unique case (state_i)
            StFetchAddr: begin
                ctrl_o.pc_oe    = 1'b1;
                ctrl_o.mar_load = 1'b1;
            end
            StFetchInstr: begin
                ctrl_o.ram_oe  = 1'b1;
                ctrl_o.ir_load = 1'b1;
                ctrl_o.pc_inc  = 1'b1;
            end
            StDecode: begin
                if (!is_defined(op_i)) begin
                    ctrl_o.illegal_op = 1'b1;
                    ctrl_o.instr_done = !HaltOnIllegal;
                end else if (op_i == OpNop) begin
                    ctrl_o.instr_done = 1'b1;
                end
            end
            StEx1: begin
                if (uses_mem(op_i)) begin
                    ctrl_o.ir_oe    = 1'b1;
                    ctrl_o.mar_load = 1'b1;
                end else if (op_i == OpLdi) begin
                    ctrl_o.ir_oe      = 1'b1;
                    ctrl_o.a_load     = 1'b1;
                    ctrl_o.instr_done = 1'b1;
                end else if (op_i == OpJmp) begin
                    ctrl_o.ir_oe      = 1'b1;
                    ctrl_o.pc_load    = 1'b1;
                    ctrl_o.instr_done = 1'b1;
                end else if (op_i == OpOut) begin
                    ctrl_o.a_oe       = 1'b1;
                    ctrl_o.out_load   = 1'b1;
                    ctrl_o.instr_done = 1'b1;
                end
            end
            StEx2: begin
                if (op_i == OpSta) begin
                    ctrl_o.a_oe   = 1'b1;
                    ctrl_o.ram_we = 1'b1;
                end else begin
                    ctrl_o.ram_oe = 1'b1;
                    ctrl_o.a_load = (op_i == OpLda);
                    ctrl_o.b_load = (op_i != OpLda);
                end
                ctrl_o.instr_done = (op_i != OpAdd) && (op_i != OpSub);
            end
            StEx3: begin
                ctrl_o.alu_oe     = 1'b1;
                ctrl_o.a_load     = 1'b1;
                ctrl_o.flags_load = 1'b1;
                ctrl_o.alu_sub    = (op_i == OpSub);
                ctrl_o.instr_done = 1'b1;
            end
            StHalt:  ctrl_o.halt = 1'b1;
            default: ctrl_o = CtrlIdle;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// SAP-1.5 fetch/decode/execute sequencer: state register, opcode latch and
// asynchronous gating of all outputs while reset is low.
module control_sequencer
    import sap_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W        = OpcodeWidth,
    parameter bit          HALT_ON_ILLEGAL = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                flag_zero,
    output logic                pc_inc,
    output logic                pc_oe,
    output logic                pc_load,
    output logic                mar_load,
    output logic                ram_oe,
    output logic                ram_we,
    output logic                ir_load,
    output logic                ir_oe,
    output logic                a_load,
    output logic                a_oe,
    output logic                b_load,
    output logic                alu_oe,
    output logic                alu_sub,
    output logic                flags_load,
    output logic                out_load,
    output logic                halt,
    output logic                illegal_op,
    output logic                instr_done
);

    state_t     state_q, state_d;
    opcode_t    op_q, op_d;
    ctrl_word_t ctrl_raw, ctrl;

    logic unused_flag_zero;
    assign unused_flag_zero = flag_zero;

    // The live opcode is used during decode so branching happens in that cycle.
    assign op_d = (state_q == StDecode) ? opcode_t'(opcode) : op_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetchAddr;
            op_q    <= OpNop;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    control_decode #(
        .HaltOnIllegal(HALT_ON_ILLEGAL)
    ) u_decode (
        .state_i     (state_q),
        .op_i        (op_d),
        .state_next_o(state_d),
        .ctrl_o      (ctrl_raw)
    );

    assign ctrl = reset ? ctrl_raw : CtrlIdle;

    assign pc_inc     = ctrl.pc_inc;
    assign pc_oe      = ctrl.pc_oe;
    assign pc_load    = ctrl.pc_load;
    assign mar_load   = ctrl.mar_load;
    assign ram_oe     = ctrl.ram_oe;
    assign ram_we     = ctrl.ram_we;
    assign ir_load    = ctrl.ir_load;
    assign ir_oe      = ctrl.ir_oe;
    assign a_load     = ctrl.a_load;
    assign a_oe       = ctrl.a_oe;
    assign b_load     = ctrl.b_load;
    assign alu_oe     = ctrl.alu_oe;
    assign alu_sub    = ctrl.alu_sub;
    assign flags_load = ctrl.flags_load;
    assign out_load   = ctrl.out_load;
    assign halt       = ctrl.halt;
    assign illegal_op = ctrl.illegal_op;
    assign instr_done = ctrl.instr_done;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: a small SAP-1.5 datapath model around the sequencer, plus a
// second instance with illegal opcodes halting.
module tb_control_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset  = 1'b0;
    logic        reset1 = 1'b0;
    logic [3:0]  opcode0;
    logic [3:0]  opcode1 = 4'h9;
    logic        fz = 1'b0;
    logic [17:0] outs0, outs1;
    int          n_cmp = 0;
    int          n_err = 0;

    localparam logic [17:0] M_PC_INC = 18'd1 << 17;
    localparam logic [17:0] M_PC_OE  = 18'd1 << 16;
    localparam logic [17:0] M_PC_LD  = 18'd1 << 15;
    localparam logic [17:0] M_MAR    = 18'd1 << 14;
    localparam logic [17:0] M_RAM_OE = 18'd1 << 13;
    localparam logic [17:0] M_RAM_WE = 18'd1 << 12;
    localparam logic [17:0] M_IR_LD  = 18'd1 << 11;
    localparam logic [17:0] M_IR_OE  = 18'd1 << 10;
    localparam logic [17:0] M_A_LD   = 18'd1 << 9;
    localparam logic [17:0] M_A_OE   = 18'd1 << 8;
    localparam logic [17:0] M_B_LD   = 18'd1 << 7;
    localparam logic [17:0] M_ALU_OE = 18'd1 << 6;
    localparam logic [17:0] M_SUB    = 18'd1 << 5;
    localparam logic [17:0] M_FLAGS  = 18'd1 << 4;
    localparam logic [17:0] M_OUT    = 18'd1 << 3;
    localparam logic [17:0] M_HALT   = 18'd1 << 2;
    localparam logic [17:0] M_ILL    = 18'd1 << 1;
    localparam logic [17:0] M_DONE   = 18'd1;
    localparam logic [17:0] M_BUS    = M_PC_OE | M_RAM_OE | M_IR_OE | M_A_OE | M_ALU_OE;
    localparam logic [17:0] E_FA     = M_PC_OE | M_MAR;
    localparam logic [17:0] E_FI     = M_RAM_OE | M_IR_LD | M_PC_INC;

    control_sequencer #(.OPCODE_W(4), .HALT_ON_ILLEGAL(1'b0)) dut (
        .clk(clk), .reset(reset), .opcode(opcode0), .flag_zero(fz),
        .pc_inc(outs0[17]), .pc_oe(outs0[16]), .pc_load(outs0[15]), .mar_load(outs0[14]),
        .ram_oe(outs0[13]), .ram_we(outs0[12]), .ir_load(outs0[11]), .ir_oe(outs0[10]),
        .a_load(outs0[9]), .a_oe(outs0[8]), .b_load(outs0[7]), .alu_oe(outs0[6]),
        .alu_sub(outs0[5]), .flags_load(outs0[4]), .out_load(outs0[3]), .halt(outs0[2]),
        .illegal_op(outs0[1]), .instr_done(outs0[0])
    );

    control_sequencer #(.OPCODE_W(4), .HALT_ON_ILLEGAL(1'b1)) dut_hi (
        .clk(clk), .reset(reset1), .opcode(opcode1), .flag_zero(fz),
        .pc_inc(outs1[17]), .pc_oe(outs1[16]), .pc_load(outs1[15]), .mar_load(outs1[14]),
        .ram_oe(outs1[13]), .ram_we(outs1[12]), .ir_load(outs1[11]), .ir_oe(outs1[10]),
        .a_load(outs1[9]), .a_oe(outs1[8]), .b_load(outs1[7]), .alu_oe(outs1[6]),
        .alu_sub(outs1[5]), .flags_load(outs1[4]), .out_load(outs1[3]), .halt(outs1[2]),
        .illegal_op(outs1[1]), .instr_done(outs1[0])
    );

    // Datapath model driven by the strobes of the first instance.
    logic [3:0] pc, mar;
    logic [7:0] ir, a, b, outr, bus, alu;
    logic       zf;
    logic [7:0] ram  [16];
    logic [7:0] prog [16];
    logic       dp_clr = 1'b1;
    logic       op_force_en = 1'b0;
    logic [3:0] op_force = 4'h0;

    always_comb begin
        alu = (outs0 & M_SUB) != 0 ? a - b : a + b;
        bus = 8'h00;
        if ((outs0 & M_PC_OE) != 0) bus = {4'h0, pc};
        else if ((outs0 & M_RAM_OE) != 0) bus = ram[mar];
        else if ((outs0 & M_IR_OE) != 0) bus = {4'h0, ir[3:0]};
        else if ((outs0 & M_A_OE) != 0) bus = a;
        else if ((outs0 & M_ALU_OE) != 0) bus = alu;
        opcode0 = op_force_en ? op_force : ir[7:4];
    end

    always @(posedge clk) begin
        if (dp_clr) begin
            pc <= 4'h0; mar <= 4'h0; ir <= 8'h00; a <= 8'h00; b <= 8'h00;
            outr <= 8'h00; zf <= 1'b0;
            for (int i = 0; i < 16; i++) ram[i] <= prog[i];
        end else begin
            if ((outs0 & M_PC_INC) != 0) pc <= pc + 4'h1;
            if ((outs0 & M_PC_LD) != 0) pc <= bus[3:0];
            if ((outs0 & M_MAR) != 0) mar <= bus[3:0];
            if ((outs0 & M_RAM_WE) != 0) ram[mar] <= bus;
            if ((outs0 & M_IR_LD) != 0) ir <= bus;
            if ((outs0 & M_A_LD) != 0) a <= bus;
            if ((outs0 & M_B_LD) != 0) b <= bus;
            if ((outs0 & M_OUT) != 0) outr <= bus;
            if ((outs0 & M_FLAGS) != 0) zf <= (alu == 8'h00);
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    endtask

    // Holds reset across an edge, then releases it; returns sampling cycle 1.
    task automatic start();
        reset = 1'b0; dp_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1; dp_clr = 1'b0;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (outs0 !== 18'h0) begin n_err++; $display("FAIL reset_low: got %h expected %h", outs0, 18'h0); end
        @(posedge clk); @(negedge clk); #1;
        n_cmp++;
        if (outs0 !== 18'h0) begin n_err++; $display("FAIL reset_held: got %h expected %h", outs0, 18'h0); end
        clear_prog();
        start();
        n_cmp++;
        if (outs0 !== E_FA) begin n_err++; $display("FAIL reset_first: got %h expected %h", outs0, E_FA); end
        next_cycle();
        n_cmp++;
        if (outs0 !== E_FI) begin n_err++; $display("FAIL reset_fi: got %h expected %h", outs0, E_FI); end
        next_cycle();
        n_cmp++;
        if (outs0 !== M_DONE) begin n_err++; $display("FAIL nop_decode: got %h expected %h", outs0, M_DONE); end
        next_cycle();
        n_cmp++;
        if (outs0 !== E_FA || pc !== 4'h1) begin
            n_err++; $display("FAIL nop_refetch: got %h pc %h expected %h pc 1", outs0, pc, E_FA);
        end
    endtask

    task automatic test_ldb();
        logic [17:0] exp_t [9];
        exp_t = '{E_FA, E_FI, 18'h0, M_IR_OE | M_MAR, M_RAM_OE | M_B_LD | M_DONE,
                  E_FA, E_FI, 18'h0, M_HALT};
        clear_prog();
        prog[0] = 8'h2E; prog[14] = 8'h11; prog[1] = 8'hFF;
        start();
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) next_cycle();
            n_cmp++;
            if (outs0 !== exp_t[c-1]) begin
                n_err++; $display("FAIL ldb_cycle%0d: got %h expected %h", c, outs0, exp_t[c-1]);
            end
        end
        n_cmp++;
        if (b !== 8'h11 || a !== 8'h00) begin
            n_err++; $display("FAIL ldb_regs: got b=%h a=%h expected b=11 a=00", b, a);
        end
    endtask

    task automatic test_add_sub();
        logic [7:0] avals [$];
        bit pend = 1'b0;
        int halt_cyc = 0, sub_n = 0, sub_bad = 0, fl_n = 0, dn_n = 0, multi = 0;
        clear_prog();
        prog[0] = 8'h1E; prog[1] = 8'h3F; prog[2] = 8'h4F; prog[3] = 8'hF0;
        prog[14] = 8'h05; prog[15] = 8'h03;
        start();
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) next_cycle();
            if (pend) begin avals.push_back(a); pend = 1'b0; end
            if ((outs0 & M_HALT) != 0) begin halt_cyc = c; break; end
            if ($countones(outs0 & M_BUS) > 1) multi++;
            if ((outs0 & M_SUB) != 0) begin
                sub_n++;
                if ((outs0 & M_ALU_OE) == 0 || ir !== 8'h4F) sub_bad++;
            end
            if ((outs0 & M_FLAGS) != 0) fl_n++;
            if ((outs0 & M_DONE) != 0) begin dn_n++; pend = 1'b1; end
        end
        n_cmp++;
        if (avals.size() != 3) begin
            n_err++; $display("FAIL addsub_nvals: got %0d expected 3", avals.size());
        end else begin
            n_cmp++;
            if (avals[1] !== 8'h08) begin n_err++; $display("FAIL add_result: got %h expected 08", avals[1]); end
            n_cmp++;
            if (avals[2] !== 8'h05) begin n_err++; $display("FAIL sub_result: got %h expected 05", avals[2]); end
        end
        n_cmp++;
        if (sub_n != 1 || sub_bad != 0) begin
            n_err++; $display("FAIL alu_sub_use: got count %0d bad %0d expected 1 and 0", sub_n, sub_bad);
        end
        n_cmp++;
        if (fl_n != 2) begin n_err++; $display("FAIL flags_load_count: got %0d expected 2", fl_n); end
        n_cmp++;
        if (dn_n != 3) begin n_err++; $display("FAIL addsub_done_count: got %0d expected 3", dn_n); end
        n_cmp++;
        if (halt_cyc != 21) begin n_err++; $display("FAIL addsub_halt_cycle: got %0d expected 21", halt_cyc); end
        n_cmp++;
        if (multi != 0) begin n_err++; $display("FAIL bus_contention: got %0d expected 0", multi); end
    endtask

    task automatic test_sta_out_jmp();
        int out_n = 0, dn_n = 0, halt_n = 0, first_out = 0;
        logic [3:0]  pc18 = 4'hF;
        logic [17:0] outs18 = '0;
        clear_prog();
        prog[0] = 8'h67; prog[1] = 8'h5D; prog[2] = 8'hE0; prog[3] = 8'h70;
        start();
        for (int c = 1; c <= 100; c++) begin
            if (c > 1) next_cycle();
            if (c == 18) begin pc18 = pc; outs18 = outs0; end
            if ((outs0 & M_OUT) != 0) begin out_n++; if (first_out == 0) first_out = c; end
            if ((outs0 & M_DONE) != 0) dn_n++;
            if ((outs0 & M_HALT) != 0) halt_n++;
        end
        n_cmp++;
        if (out_n != 6 || first_out != 13) begin
            n_err++; $display("FAIL out_load: got %0d first at %0d expected 6 first at 13", out_n, first_out);
        end
        n_cmp++;
        if (dn_n != 23) begin n_err++; $display("FAIL loop_done_count: got %0d expected 23", dn_n); end
        n_cmp++;
        if (halt_n != 0) begin n_err++; $display("FAIL loop_halt: got %0d expected 0", halt_n); end
        n_cmp++;
        if (ram[13] !== 8'h07 || outr !== 8'h07) begin
            n_err++; $display("FAIL sta_out_data: got ram13=%h out=%h expected 07 07", ram[13], outr);
        end
        n_cmp++;
        if (pc18 !== 4'h0 || outs18 !== E_FA) begin
            n_err++; $display("FAIL jmp_target: got pc=%h outs=%h expected pc=0 outs=%h", pc18, outs18, E_FA);
        end
    endtask

    task automatic test_halt_sticky();
        clear_prog();
        prog[0] = 8'hF0;
        start();
        repeat (3) next_cycle();
        n_cmp++;
        if (outs0 !== M_HALT) begin n_err++; $display("FAIL hlt_enter: got %h expected %h", outs0, M_HALT); end
        op_force_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            op_force = 4'(i * 5 + 1);
            next_cycle();
            n_cmp++;
            if (outs0 !== M_HALT) begin
                n_err++; $display("FAIL hlt_sticky%0d: got %h expected %h", i, outs0, M_HALT);
            end
        end
        op_force_en = 1'b0;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (outs0 !== 18'h0) begin n_err++; $display("FAIL hlt_reset_low: got %h expected 0", outs0); end
        clear_prog();
        start();
        n_cmp++;
        if (outs0 !== E_FA) begin n_err++; $display("FAIL hlt_restart: got %h expected %h", outs0, E_FA); end
    endtask

    task automatic test_reset_mid_add();
        clear_prog();
        prog[0] = 8'h3F; prog[15] = 8'h03;
        start();
        repeat (4) next_cycle();
        n_cmp++;
        if (outs0 !== (M_RAM_OE | M_B_LD)) begin
            n_err++; $display("FAIL add_ex2: got %h expected %h", outs0, M_RAM_OE | M_B_LD);
        end
        #1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (outs0 !== 18'h0) begin n_err++; $display("FAIL async_drop: got %h expected 0", outs0); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (outs0 !== E_FA) begin n_err++; $display("FAIL mid_restart: got %h expected %h", outs0, E_FA); end
    endtask

    task automatic test_illegal();
        logic [17:0] exp0 [7];
        logic [17:0] exp1 [5];
        exp0 = '{E_FA, E_FI, M_ILL | M_DONE, E_FA, E_FI, 18'h0, M_HALT};
        exp1 = '{E_FA, E_FI, M_ILL, M_HALT, M_HALT};
        clear_prog();
        prog[0] = 8'h90; prog[1] = 8'hF0;
        start();
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) next_cycle();
            n_cmp++;
            if (outs0 !== exp0[c-1]) begin
                n_err++; $display("FAIL illegal_nop_c%0d: got %h expected %h", c, outs0, exp0[c-1]);
            end
        end
        n_cmp++;
        if (outs1 !== 18'h0) begin n_err++; $display("FAIL illegal_hi_reset: got %h expected 0", outs1); end
        @(negedge clk);
        reset1 = 1'b1;
        #1;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) next_cycle();
            n_cmp++;
            if (outs1 !== exp1[c-1]) begin
                n_err++; $display("FAIL illegal_halt_c%0d: got %h expected %h", c, outs1, exp1[c-1]);
            end
        end
    endtask

    initial begin
        clear_prog();
        test_reset();
        test_ldb();
        test_add_sub();
        test_sta_out_jmp();
        test_halt_sticky();
        test_reset_mid_add();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
